// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: button-to-paddle step commands plus serve/play/score/game-over FSM.
// Latency: paddle commands appear one cycle after frame_tick; state/score updates take one cycle.
// Backpressure: none; all inputs are sampled every cycle and pulses must not be held off.
module pong_game_ctrl #(
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 400,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               p1_up,
  input  logic               p1_dn,
  input  logic               p2_up,
  input  logic               p2_dn,
  input  logic [9:0]         paddle1_y,
  input  logic [9:0]         paddle2_y,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic [2:0]         paddle1_ud,
  output logic [2:0]         paddle2_ud,
  output logic               ball_reset,
  output logic               ball_run,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  localparam int CNT_W = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [SCORE_W-1:0] score1_q, score1_nxt;
  logic [SCORE_W-1:0] score2_q, score2_nxt;
  logic [1:0]         winner_q, winner_nxt;
  logic               serve_dir_q, serve_dir_nxt;
  logic [2:0]         ud1_q, ud1_nxt;
  logic [2:0]         ud2_q, ud2_nxt;
  logic               start_q;
  logic               start_edge;

  // Screen y grows downward: "down" steps y+1 (bit 0), "up" steps y-1 (bit 1).
  function automatic logic [2:0] paddle_cmd(input logic up, input logic dn, input logic [9:0] y);
    logic [2:0] c;
    c    = 3'b000;
    c[0] = dn & ~up & (y < 10'(Y_MAX));
    c[1] = up & ~dn & (y > 10'(Y_MIN));
    return c;
  endfunction

  assign start_edge = start & ~start_q;

  // Start-button history for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) start_q <= 1'b0;
    else       start_q <= start;
  end

  // State and game bookkeeping registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      score1_q    <= '0;
      score2_q    <= '0;
      winner_q    <= 2'b00;
      serve_dir_q <= 1'b0;
      ud1_q       <= 3'b000;
      ud2_q       <= 3'b000;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      score1_q    <= score1_nxt;
      score2_q    <= score2_nxt;
      winner_q    <= winner_nxt;
      serve_dir_q <= serve_dir_nxt;
      ud1_q       <= ud1_nxt;
      ud2_q       <= ud2_nxt;
    end
  end

  // Next-state, scoring and paddle-command decode; a tick is judged against the current state.
  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = cnt_q;
    score1_nxt    = score1_q;
    score2_nxt    = score2_q;
    winner_nxt    = winner_q;
    serve_dir_nxt = serve_dir_q;
    ud1_nxt       = 3'b000;
    ud2_nxt       = 3'b000;

    if (frame_tick && (state_q == ST_SERVE || state_q == ST_PLAY)) begin
      ud1_nxt = paddle_cmd(p1_up, p1_dn, paddle1_y);
      ud2_nxt = paddle_cmd(p2_up, p2_dn, paddle2_y);
    end

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_nxt  = ST_SERVE;
          score1_nxt = '0;
          score2_nxt = '0;
          cnt_nxt    = '0;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
            state_nxt = ST_PLAY;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        // A double miss is a void rally: replay the serve without scoring.
        if (miss_left && !miss_right) begin
          if (score2_q < SCORE_W'(WIN_SCORE)) score2_nxt = score2_q + SCORE_W'(1);
          serve_dir_nxt = 1'b0;
          state_nxt     = ST_POINT;
        end else if (miss_right && !miss_left) begin
          if (score1_q < SCORE_W'(WIN_SCORE)) score1_nxt = score1_q + SCORE_W'(1);
          serve_dir_nxt = 1'b1;
          state_nxt     = ST_POINT;
        end else if (miss_left && miss_right) begin
          state_nxt = ST_POINT;
        end
      end
      ST_POINT: begin
        if (score1_q == SCORE_W'(WIN_SCORE)) begin
          state_nxt  = ST_GAME_OVER;
          winner_nxt = 2'b01;
        end else if (score2_q == SCORE_W'(WIN_SCORE)) begin
          state_nxt  = ST_GAME_OVER;
          winner_nxt = 2'b10;
        end else begin
          state_nxt = ST_SERVE;
        end
      end
      ST_GAME_OVER: begin
        if (start_edge) begin
          state_nxt     = ST_SERVE;
          score1_nxt    = '0;
          score2_nxt    = '0;
          winner_nxt    = 2'b00;
          serve_dir_nxt = 1'b0;
          cnt_nxt       = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ball_run   = (state_q == ST_PLAY);
  assign ball_reset = (state_q != ST_PLAY);
  assign serve_dir  = serve_dir_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign winner     = winner_q;
  assign state      = state_q;
  assign paddle1_ud = ud1_q;
  assign paddle2_ud = ud2_q;

endmodule
